// File: rtl/hpdcache_pkg.sv
// Request types of the hpdcache prefetch requester port, as consumed by the
// hardware prefetch arbiter.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_PA_WIDTH = 32;

    typedef struct packed {
        logic [HPDCACHE_PA_WIDTH-1:0] addr;
        logic [3:0]                   size;
        logic [7:0]                   tid;
    } hpdcache_req_t;

endpackage

// File: rtl/hwpf_pkg.sv
// Shared types for the hardware prefetch engines: line addresses and the
// recently-issued line filter entry.
package hwpf_pkg;

    import hpdcache_pkg::*;

    localparam int unsigned HWPF_LINE_OFFSET = 6;

    // Kept full address width so any LINE_OFFSET yields an exact line compare.
    typedef logic [HPDCACHE_PA_WIDTH-1:0] hwpf_line_t;

    typedef struct packed {
        logic       valid;
        hwpf_line_t line;
    } hwpf_filter_entry_t;

    function automatic hwpf_line_t hwpf_line(input logic [HPDCACHE_PA_WIDTH-1:0] addr,
                                             input int unsigned offset);
        return addr >> offset;
    endfunction

endpackage

// File: rtl/hwpf_rr_arbiter.sv
// Round-robin one-hot grant: first requester at or above ptr_i, wrapping
// modulo NUM_SRC.
module hwpf_rr_arbiter #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] grant_o
);

    int unsigned      idx;
    logic [PTR_W-1:0] sel;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            sel = PTR_W'(idx);
            if (!found && req_i[sel]) begin
                grant_o[sel] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hwpf_arbiter.sv
// Merges prefetcher request streams into the hpdcache prefetch port, dropping
// recently issued lines and holding the winner until the dcache accepts it.
module hwpf_arbiter
    import hpdcache_pkg::*;
    import hwpf_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned FILTER_DEPTH = 8,
    parameter int unsigned LINE_OFFSET  = HWPF_LINE_OFFSET,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [NUM_SRC-1:0]          src_req_valid_i,
    output logic [NUM_SRC-1:0]          src_req_ready_o,
    input  hpdcache_req_t [NUM_SRC-1:0] src_req_i,
    output logic                        dcache_req_valid_o,
    input  logic                        dcache_req_ready_i,
    output hpdcache_req_t               dcache_req_o,
    output logic [CNT_WIDTH-1:0]        dropped_cnt_o
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned WP_W  = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WP_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic                 out_valid_q, out_valid_d;
    hpdcache_req_t        out_req_q, out_req_d;
    logic [CNT_WIDTH-1:0] dropped_cnt_q, dropped_cnt_d;
    hwpf_filter_entry_t   filter_q [FILTER_DEPTH];
    hwpf_filter_entry_t   filter_d [FILTER_DEPTH];

    logic [NUM_SRC-1:0]      grant;
    logic                    can_accept;
    logic                    accept;
    hpdcache_req_t           acc_req;
    logic [PTR_W-1:0]        gnt_idx;
    hwpf_line_t              acc_line;
    logic [FILTER_DEPTH-1:0] filter_hit;
    logic                    hold_hit;
    logic                    is_hit;

    hwpf_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_i   (src_req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    assign can_accept      = !flush_i && (!out_valid_q || dcache_req_ready_i);
    assign src_req_ready_o = grant & {NUM_SRC{can_accept}};
    assign accept          = |src_req_ready_o;

    always_comb begin
        acc_req = '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                acc_req = src_req_i[i];
                gnt_idx = PTR_W'(i);
            end
        end
    end

    assign acc_line = hwpf_line(acc_req.addr, LINE_OFFSET);

    for (genvar gi = 0; gi < FILTER_DEPTH; gi++) begin : g_filter_cmp
        assign filter_hit[gi] = filter_q[gi].valid && (filter_q[gi].line == acc_line);
    end

    // The held request only counts while it is not leaving this cycle.
    assign hold_hit = out_valid_q && !dcache_req_ready_i &&
                      (hwpf_line(out_req_q.addr, LINE_OFFSET) == acc_line);
    assign is_hit   = (|filter_hit) || hold_hit;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        out_valid_d   = out_valid_q;
        out_req_d     = out_req_q;
        dropped_cnt_d = dropped_cnt_q;
        filter_d      = filter_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
            wr_ptr_d    = '0;
            for (int e = 0; e < FILTER_DEPTH; e++) begin
                filter_d[e].valid = 1'b0;
            end
        end else begin
            if (out_valid_q && dcache_req_ready_i) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                rr_ptr_d = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
                if (is_hit) begin
                    if (dropped_cnt_q != '1) begin
                        dropped_cnt_d = dropped_cnt_q + 1'b1;
                    end
                end else begin
                    out_valid_d        = 1'b1;
                    out_req_d          = acc_req;
                    filter_d[wr_ptr_q] = '{valid: 1'b1, line: acc_line};
                    wr_ptr_d = (wr_ptr_q == WP_W'(FILTER_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_req_q     <= '0;
            dropped_cnt_q <= '0;
            for (int e = 0; e < FILTER_DEPTH; e++) begin
                filter_q[e] <= '0;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            out_valid_q   <= out_valid_d;
            out_req_q     <= out_req_d;
            dropped_cnt_q <= dropped_cnt_d;
            filter_q      <= filter_d;
        end
    end

    // A held request is withdrawn in a flush cycle even if the dcache is ready.
    assign dcache_req_valid_o = out_valid_q && !flush_i;
    assign dcache_req_o       = out_req_q;
    assign dropped_cnt_o      = dropped_cnt_q;

endmodule

// File: tb/tb_hwpf_arbiter.sv
// Self-checking bench for hwpf_arbiter: per-cycle vectors for handshake
// signals plus an issue-order scoreboard on the dcache port.
module tb_hwpf_arbiter;
    import hpdcache_pkg::*;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        rdy;
        logic        fl;
        logic [1:0]  exp_ready;
        logic        exp_valid;
        int          exp_drop;
        logic        push;
        logic [31:0] push_addr;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic [1:0]          src_valid = '0;
    logic [1:0]          src_ready;
    hpdcache_req_t [1:0] src_req;
    logic                dvalid;
    logic                dready = 1'b0;
    hpdcache_req_t       dreq;
    logic [15:0]         dropped;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];

    hwpf_arbiter dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .flush_i            (flush),
        .src_req_valid_i    (src_valid),
        .src_req_ready_o    (src_ready),
        .src_req_i          (src_req),
        .dcache_req_valid_o (dvalid),
        .dcache_req_ready_i (dready),
        .dcache_req_o       (dreq),
        .dropped_cnt_o      (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard: every dcache handshake must match the oldest expected issue.
    always @(negedge clk) begin
        if (rst_n && dvalid && dready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL issue_unexpected got=%h exp=none", dreq.addr);
            end else begin
                logic [31:0] exp_addr;
                exp_addr = sb_q.pop_front();
                $display("ISSUE addr=%h exp=%h", dreq.addr, exp_addr);
                check("issue_addr", dreq.addr, exp_addr);
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
                                input logic rdy, input logic fl, input logic [1:0] er,
                                input logic ev, input int ed, input logic push,
                                input logic [31:0] pa);
        vec_t v;
        v.vld = vld; v.a0 = a0; v.a1 = a1; v.rdy = rdy; v.fl = fl;
        v.exp_ready = er; v.exp_valid = ev; v.exp_drop = ed;
        v.push = push; v.push_addr = pa;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        src_valid       = v.vld;
        src_req[0].addr = v.a0;
        src_req[1].addr = v.a1;
        dready          = v.rdy;
        flush           = v.fl;
        if (v.push) sb_q.push_back(v.push_addr);
        @(negedge clk);
        $display("VEC vld=%b a0=%h a1=%h rdy=%b fl=%b -> ready=%b valid=%b drop=%0d",
                 v.vld, v.a0, v.a1, v.rdy, v.fl, src_ready, dvalid, dropped);
        check("src_ready", 32'(src_ready), 32'(v.exp_ready));
        check("dvalid", 32'(dvalid), 32'(v.exp_valid));
        check("dropped", 32'(dropped), 32'(v.exp_drop));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[8];

    initial begin
        int i0;
        int i1;
        logic [31:0] a0;
        logic [31:0] a1;
        src_req = '0;

        // Reset state with no stimulus
        @(negedge clk);
        check("rst_valid", 32'(dvalid), 32'd0);
        check("rst_ready", 32'(src_ready), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        check("rst_payload", dreq.addr, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request, back-to-back sources, flush, same-line pair
        tbl[0] = mk(2'b01, 32'hCAFE0040, 32'h0, 1, 0, 2'b01, 0, 0, 1, 32'hCAFE0040);
        tbl[1] = mk(2'b00, 32'h0,        32'h0, 1, 0, 2'b00, 1, 0, 0, 32'h0);
        tbl[2] = mk(2'b10, 32'h0,  32'h00002000, 1, 0, 2'b10, 0, 0, 1, 32'h00002000);
        tbl[3] = mk(2'b00, 32'h0,        32'h0, 1, 0, 2'b00, 1, 0, 0, 32'h0);
        tbl[4] = mk(2'b00, 32'h0,        32'h0, 1, 1, 2'b00, 0, 0, 0, 32'h0);
        tbl[5] = mk(2'b11, 32'hCAFE0040, 32'hCAFE0048, 1, 0, 2'b01, 0, 0, 1, 32'hCAFE0040);
        tbl[6] = mk(2'b10, 32'h0,        32'hCAFE0048, 1, 0, 2'b10, 1, 0, 0, 32'h0);
        tbl[7] = mk(2'b00, 32'h0,        32'h0, 1, 0, 2'b00, 0, 1, 0, 32'h0);
        for (int i = 0; i < 8; i++) apply(tbl[i]);

        // Both sources streaming distinct lines: grants alternate
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 8; c++) begin
            a0 = 32'h1000 + 32'(64 * (2 * i0));
            a1 = 32'h1000 + 32'(64 * (2 * i1 + 1));
            if (c % 2 == 0) begin
                apply(mk(2'b11, a0, a1, 1, 0, 2'b01, c > 0, 1, 1, a0));
                i0++;
            end else begin
                apply(mk(2'b11, a0, a1, 1, 0, 2'b10, 1, 1, 1, a1));
                i1++;
            end
        end
        apply(mk(2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 1, 1, 0, 32'h0));
        apply(mk(2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 0, 1, 0, 32'h0));

        // Backpressure: held request stays stable, other source stalls
        apply(mk(2'b01, 32'hCAFE0080, 32'h0, 0, 0, 2'b01, 0, 1, 1, 32'hCAFE0080));
        for (int c = 0; c < 5; c++) begin
            apply(mk(2'b10, 32'h0, 32'hCAFE00C0, 0, 0, 2'b00, 1, 1, 0, 32'h0));
            check("hold_payload", dreq.addr, 32'hCAFE0080);
        end
        apply(mk(2'b10, 32'h0, 32'hCAFE00C0, 1, 0, 2'b10, 1, 1, 1, 32'hCAFE00C0));
        apply(mk(2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 1, 1, 0, 32'h0));
        apply(mk(2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 0, 1, 0, 32'h0));

        // Filter eviction, hit after refill, then flush withdraws held request
        apply(mk(2'b00, 32'h0, 32'h0, 1, 1, 2'b00, 0, 1, 0, 32'h0));
        for (int k = 0; k < 9; k++) begin
            a0 = 32'h8000 + 32'(64 * k);
            apply(mk(2'b01, a0, 32'h0, 1, 0, 2'b01, k > 0, 1, 1, a0));
        end
        apply(mk(2'b01, 32'h8000, 32'h0, 1, 0, 2'b01, 1, 1, 1, 32'h8000));
        apply(mk(2'b01, 32'h8080, 32'h0, 1, 0, 2'b01, 1, 1, 0, 32'h0));
        apply(mk(2'b01, 32'h8240, 32'h0, 1, 0, 2'b01, 0, 2, 0, 32'h0));
        apply(mk(2'b01, 32'h80C0, 32'h0, 1, 1, 2'b00, 0, 2, 0, 32'h0));
        apply(mk(2'b01, 32'h80C0, 32'h0, 1, 0, 2'b01, 0, 2, 1, 32'h80C0));
        apply(mk(2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 1, 2, 0, 32'h0));
        apply(mk(2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 0, 2, 0, 32'h0));

        // Asynchronous reset while a request is held
        apply(mk(2'b01, 32'h9000, 32'h0, 0, 0, 2'b01, 0, 2, 0, 32'h0));
        src_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(dvalid), 32'd0);
        check("async_rst_dropped", 32'(dropped), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply(mk(2'b01, 32'h9000, 32'h0, 1, 0, 2'b01, 0, 0, 1, 32'h9000));
        apply(mk(2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 1, 0, 0, 32'h0));
        apply(mk(2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 0, 0, 0, 32'h0));

        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
